bundle_sequencer: RTL and testbench



---
 rtl/bundle_pkg.sv | 19 +
 rtl/bundle_sequencer_if.sv | 27 ++
 rtl/bundle_binarize.sv | 32 +++
 rtl/bundle_sequencer.sv | 118 +++++++++++
 tb/tb_bundle_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/bundle_pkg.sv
// Shared types and elaboration-time helpers for the serial majority bundler.
package bundle_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  // Counter width able to hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  // Neighbour bit consulted when an even-sized window ties on bit i.
  function automatic int tie_idx(input int i, input int dims);
    return (i + 1) % dims;
  endfunction

endpackage

// File: rtl/bundle_sequencer_if.sv
// Input/output stream bundle for bundle_sequencer; slave is the bundler side.
interface bundle_sequencer_if import bundle_pkg::*; #(
  parameter int DIMENSIONS = 10000,
  parameter int NUM_HVS    = 17
);

  localparam int CW = cnt_w(NUM_HVS);

  logic [DIMENSIONS-1:0] hv_in;
  logic                  hv_in_valid;
  logic                  hv_in_ready;
  logic [DIMENSIONS-1:0] hv_out;
  logic                  hv_out_valid;
  logic                  hv_out_ready;
  logic [CW-1:0]         hv_index;

  modport slave (
    input  hv_in, hv_in_valid, hv_out_ready,
    output hv_in_ready, hv_out, hv_out_valid, hv_index
  );

  modport master (
    output hv_in, hv_in_valid, hv_out_ready,
    input  hv_in_ready, hv_out, hv_out_valid, hv_index
  );

endinterface

// File: rtl/bundle_binarize.sv
// Combinational thresholding of per-dimension ones-counts into one bundled HV.
module bundle_binarize import bundle_pkg::*; #(
  parameter int DIMENSIONS = 10000,
  parameter int NUM_HVS    = 17
) (
  input  logic [DIMENSIONS-1:0][cnt_w(NUM_HVS)-1:0] ones_i,
  input  logic [DIMENSIONS-1:0]                     first_hv_i,
  input  logic [DIMENSIONS-1:0]                     last_hv_i,
  output logic [DIMENSIONS-1:0]                     hv_o
);

  localparam int CW = cnt_w(NUM_HVS);

  if (NUM_HVS % 2 == 1) begin : g_odd
    localparam logic [CW-1:0] HALF = CW'((NUM_HVS - 1) / 2);
    // Odd windows never tie, so the tie-break operands are deliberately dropped.
    logic unused_tie;
    assign unused_tie = ^{first_hv_i, last_hv_i};
    for (genvar i = 0; i < DIMENSIONS; i++) begin : g_bit
      assign hv_o[i] = (ones_i[i] > HALF);
    end
  end else begin : g_even
    localparam logic [CW-1:0] HALF = CW'(NUM_HVS / 2);
    for (genvar i = 0; i < DIMENSIONS; i++) begin : g_bit
      localparam int J = tie_idx(i, DIMENSIONS);
      assign hv_o[i] = (ones_i[i] > HALF) ? 1'b1 :
                       (ones_i[i] < HALF) ? 1'b0 :
                       (first_hv_i[J] ^ last_hv_i[J]);
    end
  end

endmodule

// File: rtl/bundle_sequencer.sv
// Streaming majority bundler: counts ones over NUM_HVS serial inputs, then
// holds one binarized HV until downstream takes it.
module bundle_sequencer import bundle_pkg::*; #(
  parameter int DIMENSIONS = 10000,
  parameter int NUM_HVS    = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               abort,
  bundle_sequencer_if.slave  bus
);

  localparam int              CW       = cnt_w(NUM_HVS);
  localparam logic [CW-1:0]   LAST_IDX = CW'(NUM_HVS - 1);

  state_t                         state_q, state_d;
  logic [DIMENSIONS-1:0][CW-1:0]  ones_q, ones_d, ones_nx;
  logic [DIMENSIONS-1:0]          first_q, first_d, first_sel;
  logic [DIMENSIONS-1:0]          hv_out_q, hv_out_d, bin_hv;
  logic [CW-1:0]                  idx_q, idx_d;
  logic                           vld_q, vld_d;
  logic                           accept, last;

  assign bus.hv_in_ready  = (state_q == ACCUM);
  assign bus.hv_out       = hv_out_q;
  assign bus.hv_out_valid = vld_q;
  assign bus.hv_index     = idx_q;

  assign accept = bus.hv_in_valid && (state_q == ACCUM);
  assign last   = (idx_q == LAST_IDX);

  always_comb begin
    ones_nx = ones_q;
    for (int i = 0; i < DIMENSIONS; i++) begin
      ones_nx[i] = ones_q[i] + CW'(bus.hv_in[i]);
    end
  end

  // A one-HV window has no stored first HV yet; the incoming HV is both ends.
  if (NUM_HVS == 1) begin : g_single
    logic unused_first;
    assign unused_first = ^first_q;
    assign first_sel    = bus.hv_in;
  end else begin : g_multi
    assign first_sel = first_q;
  end

  bundle_binarize #(
    .DIMENSIONS (DIMENSIONS),
    .NUM_HVS    (NUM_HVS)
  ) u_binarize (
    .ones_i     (ones_nx),
    .first_hv_i (first_sel),
    .last_hv_i  (bus.hv_in),
    .hv_o       (bin_hv)
  );

  always_comb begin
    state_d  = state_q;
    ones_d   = ones_q;
    first_d  = first_q;
    idx_d    = idx_q;
    hv_out_d = hv_out_q;
    vld_d    = vld_q;
    if (abort) begin
      state_d = ACCUM;
      ones_d  = '0;
      first_d = '0;
      idx_d   = '0;
      vld_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (last) begin
              hv_out_d = bin_hv;
              vld_d    = 1'b1;
              state_d  = EMIT;
              ones_d   = '0;
              first_d  = '0;
              idx_d    = '0;
            end else begin
              ones_d = ones_nx;
              idx_d  = idx_q + CW'(1);
              if (idx_q == '0) first_d = bus.hv_in;
            end
          end
        end
        EMIT: begin
          if (bus.hv_out_ready) begin
            state_d = ACCUM;
            vld_d   = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACCUM;
      ones_q   <= '0;
      first_q  <= '0;
      idx_q    <= '0;
      hv_out_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ones_q   <= ones_d;
      first_q  <= first_d;
      idx_q    <= idx_d;
      hv_out_q <= hv_out_d;
      vld_q    <= vld_d;
    end
  end

endmodule

// File: tb/tb_bundle_sequencer.sv
// Directed bench for bundle_sequencer: three instances (8x3, 4x2, 8x1) checked
// every cycle against a window-level majority model plus literal expectations.
module tb_bundle_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] in_hv   [3];
  logic       in_vld  [3];
  logic       out_rdy [3];
  logic       abt     [3];
  logic [7:0] o_hv    [3];
  logic       o_vld   [3];
  logic       i_rdy   [3];
  int         o_idx   [3];

  int checks = 0;
  int errors = 0;

  bundle_sequencer_if #(.DIMENSIONS(8), .NUM_HVS(3)) b0 ();
  bundle_sequencer_if #(.DIMENSIONS(4), .NUM_HVS(2)) b1 ();
  bundle_sequencer_if #(.DIMENSIONS(8), .NUM_HVS(1)) b2 ();

  assign b0.hv_in        = in_hv[0];
  assign b0.hv_in_valid  = in_vld[0];
  assign b0.hv_out_ready = out_rdy[0];
  assign b1.hv_in        = in_hv[1][3:0];
  assign b1.hv_in_valid  = in_vld[1];
  assign b1.hv_out_ready = out_rdy[1];
  assign b2.hv_in        = in_hv[2];
  assign b2.hv_in_valid  = in_vld[2];
  assign b2.hv_out_ready = out_rdy[2];

  assign o_hv[0]  = b0.hv_out;
  assign o_hv[1]  = {4'b0000, b1.hv_out};
  assign o_hv[2]  = b2.hv_out;
  assign o_vld[0] = b0.hv_out_valid;
  assign o_vld[1] = b1.hv_out_valid;
  assign o_vld[2] = b2.hv_out_valid;
  assign i_rdy[0] = b0.hv_in_ready;
  assign i_rdy[1] = b1.hv_in_ready;
  assign i_rdy[2] = b2.hv_in_ready;
  assign o_idx[0] = int'(b0.hv_index);
  assign o_idx[1] = int'(b1.hv_index);
  assign o_idx[2] = int'(b2.hv_index);

  bundle_sequencer #(.DIMENSIONS(8), .NUM_HVS(3)) u0 (
    .clk(clk), .rst(rst), .abort(abt[0]), .bus(b0));
  bundle_sequencer #(.DIMENSIONS(4), .NUM_HVS(2)) u1 (
    .clk(clk), .rst(rst), .abort(abt[1]), .bus(b1));
  bundle_sequencer #(.DIMENSIONS(8), .NUM_HVS(1)) u2 (
    .clk(clk), .rst(rst), .abort(abt[2]), .bus(b2));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Window-level model: remember the HVs of the open window, majority-vote
  // them when the window fills, and hold the result until it is taken.
  int         n_of [3] = '{3, 2, 1};
  int         d_of [3] = '{8, 4, 8};
  logic [7:0] win  [3][3];
  int         wcnt [3] = '{0, 0, 0};
  bit         emit [3] = '{0, 0, 0};
  bit         exp_vld [3] = '{0, 0, 0};
  logic [7:0] exp_hv  [3] = '{8'h00, 8'h00, 8'h00};

  function automatic logic [7:0] bundle_of(input int k);
    logic [7:0] r;
    int c, m;
    r = 8'h00;
    for (int i = 0; i < d_of[k]; i++) begin
      c = 0;
      for (int j = 0; j < n_of[k]; j++) c += int'(win[k][j][i]);
      if (2 * c > n_of[k]) r[i] = 1'b1;
      else if (2 * c == n_of[k]) begin
        m = (i + 1) % d_of[k];
        r[i] = win[k][0][m] ^ win[k][n_of[k]-1][m];
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        wcnt[k] = 0; emit[k] = 0; exp_vld[k] = 0; exp_hv[k] = 8'h00;
      end else if (abt[k]) begin
        wcnt[k] = 0; emit[k] = 0; exp_vld[k] = 0;
      end else if (!emit[k]) begin
        if (in_vld[k]) begin
          win[k][wcnt[k]] = (d_of[k] == 8) ? in_hv[k] : (in_hv[k] & 8'h0F);
          wcnt[k] = wcnt[k] + 1;
          if (wcnt[k] == n_of[k]) begin
            exp_hv[k] = bundle_of(k);
            exp_vld[k] = 1; emit[k] = 1; wcnt[k] = 0;
          end
        end
      end else if (out_rdy[k]) begin
        emit[k] = 0; exp_vld[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_rdy%0d", k), 32'(i_rdy[k]), 32'(!emit[k]));
      chk($sformatf("model_vld%0d", k), 32'(o_vld[k]), 32'(exp_vld[k]));
      chk($sformatf("model_idx%0d", k), 32'(o_idx[k]), 32'(wcnt[k]));
      if (exp_vld[k]) chk($sformatf("model_hv%0d", k), 32'(o_hv[k]), 32'(exp_hv[k]));
    end
  end

  task automatic drive(input int k, input logic [7:0] hv);
    in_hv[k] = hv;
    in_vld[k] = 1'b1;
    @(negedge clk);
    in_vld[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_hv[k] = 8'h00; in_vld[k] = 1'b0; out_rdy[k] = 1'b1; abt[k] = 1'b0;
    end
    idle(2);
    for (int k = 0; k < 3; k++) begin
      chk("reset_hv", 32'(o_hv[k]), 32'h0);
      chk("reset_vld", 32'(o_vld[k]), 32'h0);
      chk("reset_idx", 32'(o_idx[k]), 32'h0);
      chk("reset_rdy", 32'(i_rdy[k]), 32'h1);
    end
    rst = 1'b0;
    idle(1);

    // Odd majority, back-to-back: valid seen on cycle 4 for exactly one cycle
    drive(0, 8'hCA); drive(0, 8'hA6); drive(0, 8'h93);
    chk("odd_hv", 32'(o_hv[0]), 32'h82);
    chk("odd_vld", 32'(o_vld[0]), 32'h1);
    idle(1);
    chk("odd_vld_once", 32'(o_vld[0]), 32'h0);

    // Gapped input
    chk("gap_idx0", 32'(o_idx[0]), 32'd0);
    drive(0, 8'hCA);
    chk("gap_idx1", 32'(o_idx[0]), 32'd1);
    idle(2);
    chk("gap_idx1_hold", 32'(o_idx[0]), 32'd1);
    drive(0, 8'hA6);
    chk("gap_idx2", 32'(o_idx[0]), 32'd2);
    idle(2);
    drive(0, 8'h93);
    chk("gap_hv", 32'(o_hv[0]), 32'h82);
    chk("gap_vld", 32'(o_vld[0]), 32'h1);
    idle(1);

    // Backpressure with hv_in_valid held high
    out_rdy[0] = 1'b0;
    drive(0, 8'h11); drive(0, 8'h13); drive(0, 8'h22);
    chk("bp_hv", 32'(o_hv[0]), 32'h13);
    in_hv[0] = 8'hFF; in_vld[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_hv", 32'(o_hv[0]), 32'h13);
      chk("bp_hold_vld", 32'(o_vld[0]), 32'h1);
      chk("bp_in_rdy", 32'(i_rdy[0]), 32'h0);
      chk("bp_idx", 32'(o_idx[0]), 32'd0);
    end
    out_rdy[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_vld", 32'(o_vld[0]), 32'h0);
    chk("bp_release_idx", 32'(o_idx[0]), 32'd0);
    @(negedge clk);
    chk("bp_next_window", 32'(o_idx[0]), 32'd1);
    in_vld[0] = 1'b0;
    drive(0, 8'hFF); drive(0, 8'hFF);
    chk("bp_second_hv", 32'(o_hv[0]), 32'hFF);
    idle(1);

    // abort coincident with the 2nd accept
    drive(0, 8'hF0);
    in_hv[0] = 8'h0F; in_vld[0] = 1'b1; abt[0] = 1'b1;
    @(negedge clk);
    abt[0] = 1'b0; in_vld[0] = 1'b0;
    chk("abort_idx", 32'(o_idx[0]), 32'd0);
    drive(0, 8'h01); drive(0, 8'h03); drive(0, 8'h07);
    chk("abort_hv", 32'(o_hv[0]), 32'h03);
    idle(1);

    // Even tie-break including the bit-3 wrap to bit 0
    drive(1, 8'h03); drive(1, 8'h05);
    chk("even_tie_hv", 32'(o_hv[1]), 32'h3);
    idle(1);
    drive(1, 8'h08); drive(1, 8'h01);
    chk("even_wrap_hv", 32'(o_hv[1]), 32'h8);
    idle(1);

    // NUM_HVS=1 echo at one HV per two cycles
    foreach (n_of[k]) begin
      logic [7:0] v;
      v = (k == 0) ? 8'h5A : (k == 1) ? 8'hC3 : 8'hFF;
      in_hv[2] = v; in_vld[2] = 1'b1;
      @(negedge clk);
      chk("one_echo_hv", 32'(o_hv[2]), 32'(v));
      chk("one_echo_vld", 32'(o_vld[2]), 32'h1);
      @(negedge clk);
      chk("one_gap_vld", 32'(o_vld[2]), 32'h0);
      chk("one_gap_rdy", 32'(i_rdy[2]), 32'h1);
    end
    in_vld[2] = 1'b0;
    idle(1);

    // Asynchronous reset while a bundle is being presented
    drive(0, 8'hCA); drive(0, 8'hA6); drive(0, 8'h93);
    chk("rst_pre_vld", 32'(o_vld[0]), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_vld", 32'(o_vld[0]), 32'h0);
    chk("rst_async_hv", 32'(o_hv[0]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 8'h01); drive(0, 8'h01); drive(0, 8'h00);
    chk("post_rst_hv", 32'(o_hv[0]), 32'h01);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
